// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: core valid/ready load/store in, APB SETUP/ACCESS out,
// read data or error returned on a valid/ready response channel.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              apb_sel,
    output logic              apb_enable,
    output logic              apb_write,
    output logic [ADDR_W-1:0] apb_addr,
    output logic [31:0]       apb_wdata,
    output logic [3:0]        apb_strb,
    input  logic [31:0]       apb_rdata,
    input  logic              apb_ready,
    input  logic              apb_slverr
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              bad_req;
    logic              busy;

    assign bad_req = (req_size == 2'd3)
                   || ((req_size == 2'd1) && req_addr[0])
                   || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    unique case (req_size)
                        2'd0:    strb_d = 4'b0001;
                        2'd1:    strb_d = 4'b0011;
                        default: strb_d = 4'b1111;
                    endcase
                    if (bad_req) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // ready wins over a timeout expiring in the same cycle
                if (apb_ready) begin
                    rdata_d = (write_q || apb_slverr) ? '0 : apb_rdata;
                    err_d   = apb_slverr;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == SETUP) || (state_q == ACCESS);
    assign apb_sel    = busy;
    assign apb_enable = (state_q == ACCESS);
    assign apb_write  = busy & write_q;
    assign apb_addr   = busy ? addr_q  : '0;
    assign apb_wdata  = busy ? wdata_q : '0;
    assign apb_strb   = busy ? strb_q  : '0;

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err    = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: 16-word APB memory model with programmable
// wait states, plus a second instance with TIMEOUT=4 facing a slave that never answers.
`timescale 1ns/1ps
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid2, req_ready, req_ready2;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        apb_sel, apb_enable, apb_write, apb_ready, apb_slverr;
    logic [31:0] apb_addr, apb_wdata, apb_rdata;
    logic [3:0]  apb_strb;

    logic        rsp_valid2, rsp_err2;
    logic [31:0] rsp_rdata2;
    logic        sel2, en2, wr2;
    logic [31:0] addr2, wd2;
    logic [3:0]  strb2;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [32:0] sb_q[$];

    logic [31:0] mem [16];
    int          wait_n = 0;
    int          acc_cnt = 0;
    logic        sel_seen;
    int          acc_n;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_strb;
    logic        snap_write;

    always #5 clk = ~clk;

    apb_master_bridge #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_strb(apb_strb),
        .apb_rdata(apb_rdata), .apb_ready(apb_ready), .apb_slverr(apb_slverr)
    );

    apb_master_bridge #(.TIMEOUT(4), .ADDR_W(32)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .apb_sel(sel2), .apb_enable(en2), .apb_write(wr2),
        .apb_addr(addr2), .apb_wdata(wd2), .apb_strb(strb2),
        .apb_rdata(32'hBAD0_BAD0), .apb_ready(1'b0), .apb_slverr(1'b0)
    );

    // Memory slave: word-indexed, addresses above 0x3F answer with slverr.
    assign apb_ready  = apb_sel & apb_enable & (acc_cnt >= wait_n);
    assign apb_slverr = apb_ready & (apb_addr[31:6] != 26'd0);
    assign apb_rdata  = mem[apb_addr[5:2]];

    always @(posedge clk) begin
        acc_cnt <= (apb_sel && apb_enable && !apb_ready) ? acc_cnt + 1 : 0;
        if (apb_ready && apb_write && !apb_slverr) begin
            for (int b = 0; b < 4; b++)
                if (apb_strb[b]) mem[apb_addr[5:2]][8*b +: 8] <= apb_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor and scoreboard consumer, sampled away from the clock edge.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            chk("en_needs_sel", apb_enable & ~apb_sel, 0);
            if (!apb_sel) begin
                chk("idle_bus", {apb_addr | apb_wdata, 27'd0, apb_write, apb_strb}, 0);
            end else begin
                sel_seen = 1'b1;
                if (!apb_enable) begin
                    snap_addr  = apb_addr;
                    snap_wdata = apb_wdata;
                    snap_strb  = apb_strb;
                    snap_write = apb_write;
                    acc_n      = 0;
                end else begin
                    acc_n++;
                    chk("acc_addr", apb_addr, snap_addr);
                    chk("acc_wdata", apb_wdata, snap_wdata);
                    chk("acc_ctl", {apb_write, apb_strb}, {snap_write, snap_strb});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e[32:1]);
                    chk("rsp_err", rsp_err, e[0]);
                end
            end
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input logic [3:0] es, input int lat_exp, input int stall);
        int n;
        int lat;
        sb_q.push_back({er, ee});
        rsp_ready = (stall == 0);
        @(negedge clk);
        sel_seen  = 1'b0;
        req_write = w;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 0, 1);
            req_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, lat_exp);
        for (int i = 0; i < stall; i++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, er);
            chk("hold_err", rsp_err, ee);
            chk("hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        if (es == 4'b0000) begin
            chk("no_sel", sel_seen, 0);
        end else begin
            chk("strb", snap_strb, es);
            chk("setup_addr", snap_addr, a);
            chk("setup_write", snap_write, w);
        end
    endtask

    initial begin
        int acc;
        int k;
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int k;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h1234_5678;
        mem[2] = 32'hFFFF_FFFF;
        rst = 1'b1;
        req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
        req_addr = '0; req_size = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bus", {apb_sel, apb_enable, apb_write, apb_strb}, 0);
        chk("rst_addr_wdata", {apb_addr, apb_wdata}, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;

        send(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b1111, 3, 0);
        send(1'b0, 32'h10, 2'd2, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 3, 0);
        send(1'b1, 32'h08, 2'd0, 32'h0000_0055, 32'h0,         1'b0, 4'b0001, 3, 0);
        send(1'b1, 32'h08, 2'd1, 32'h0000_A5A5, 32'h0,         1'b0, 4'b0011, 3, 0);
        send(1'b0, 32'h08, 2'd2, 32'h0,         32'hFFFF_A5A5, 1'b0, 4'b1111, 3, 0);

        wait_n = 5;
        send(1'b0, 32'h10, 2'd2, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 8, 0);
        chk("wait_access_cycles", acc_n, 6);
        wait_n = 0;

        send(1'b0, 32'h100, 2'd2, 32'h0,        32'h0,         1'b1, 4'b1111, 3, 0);
        send(1'b0, 32'h03,  2'd1, 32'h0,        32'h0,         1'b1, 4'b0000, 1, 0);
        send(1'b1, 32'h02,  2'd2, 32'h1111_2222, 32'h0,        1'b1, 4'b0000, 1, 0);
        send(1'b0, 32'h00,  2'd3, 32'h0,        32'h0,         1'b1, 4'b0000, 1, 0);
        send(1'b0, 32'h10,  2'd2, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b1111, 3, 3);

        // Reset while the slave stalls in ACCESS: bus drops, no response follows.
        wait_n = 10;
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_access", {apb_sel, apb_enable}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_bus", {apb_sel, apb_enable}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_n = 0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        chk("rst_sb_empty", sb_q.size(), 0);

        // TIMEOUT=4 instance: slave never ready.
        chk("to_req_ready", req_ready2, 1);
        req_write = 1'b0; req_addr = 32'h20; req_size = 2'd2; req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        acc = 0;
        k = 0;
        while (!rsp_valid2 && k < 40) begin
            if (sel2 && en2) acc++;
            @(negedge clk);
            k++;
        end
        chk("to_rsp_seen", rsp_valid2, 1);
        chk("to_access_cycles", acc, 4);
        chk("to_sel_dropped", {sel2, en2}, 0);
        chk("to_err", rsp_err2, 1);
        chk("to_rdata", rsp_rdata2, 0);
        chk("to_bus_idle", {addr2 | wd2, 27'd0, wr2, strb2}, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
